// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder: the carry chain is cut into STAGES segments with a register per segment.
// Optional subtract mode under `PIPE_ADDER_SUB_EN` (adds port Sub; Sub=1 computes A + ~B + 1).
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef PIPE_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int SEG = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $fatal(1, "pipe_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // All stages advance together whenever the output slot is empty or being consumed.
  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // Subtraction is folded in at the entry, so the inverted operand travels with the transaction.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  always_comb begin
    b_eff   = B;
    cin_eff = Cin;
`ifdef PIPE_ADDER_SUB_EN
    if (Sub) begin
      b_eff   = ~B;
      cin_eff = 1'b1;
    end
`endif
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO   = k * SEG;
    localparam int HI   = (k + 1) * SEG;
    localparam bit LAST = (k == STAGES - 1);

    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic           c_in;
    logic           v_in;
    logic [SEG:0]   seg_res;
    logic [HI-1:0]  s_nx;
    logic           v_q;
    logic           c_q;
    logic [HI-1:0]  s_q;

    assign seg_res = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_in};

    if (k == 0) begin : g_head
      assign a_seg = A[SEG-1:0];
      assign b_seg = b_eff[SEG-1:0];
      assign c_in  = cin_eff;
      assign v_in  = in_valid;
      assign s_nx  = seg_res[SEG-1:0];
    end else begin : g_link
      assign a_seg = g_stg[k-1].g_skew.a_q[SEG-1:0];
      assign b_seg = g_stg[k-1].g_skew.b_q[SEG-1:0];
      assign c_in  = g_stg[k-1].c_q;
      assign v_in  = g_stg[k-1].v_q;
      assign s_nx  = {seg_res[SEG-1:0], g_stg[k-1].s_q};
    end

    // The last stage only loads on a valid slot so the previous result stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        if (!LAST || v_in) begin
          s_q <= s_nx;
          c_q <= seg_res[SEG];
        end
      end
    end

    // Skew registers hold the operand bits that later segments have yet to add.
    if (k < STAGES - 1) begin : g_skew
      localparam int RW = WIDTH - HI;
      logic [RW-1:0] a_q;
      logic [RW-1:0] b_q;
      logic [RW-1:0] a_nx;
      logic [RW-1:0] b_nx;

      if (k == 0) begin : g_src_in
        assign a_nx = A[WIDTH-1:HI];
        assign b_nx = b_eff[WIDTH-1:HI];
      end else begin : g_src_prev
        assign a_nx = g_stg[k-1].g_skew.a_q[WIDTH-LO-1:SEG];
        assign b_nx = g_stg[k-1].g_skew.b_q[WIDTH-LO-1:SEG];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_nx;
          b_q <= b_nx;
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign Sum       = g_stg[STAGES-1].s_q;
  assign Carry     = g_stg[STAGES-1].c_q;

endmodule
